// File: rtl/mem_responder.sv
// Valid/ready memory responder: single read/write requests, fixed wait states,
// registered ready/rdata, protocol-abort detection and a wrapping transfer counter.
module mem_responder #(
  parameter int ADDR_WIDTH  = 5,
  parameter int WIDTH       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_rd,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  proto_err,
  output logic [15:0]           xfer_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                 state, state_n;
  logic [3:0]             cnt;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic                   lat_wr;
  logic [WIDTH-1:0]       lat_wdata;
  logic [WIDTH-1:0]       mem [DEPTH];

  logic                   accept, complete, violation, load_rd, rd_is_read;
  logic [ADDR_WIDTH-1:0]  rd_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (valid) state_n = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!valid)          state_n = S_IDLE;
        else if (cnt == '0)  state_n = S_ACK;
      end
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // With zero wait states the read is loaded on the accept edge itself,
  // so the live request fields stand in for the not-yet-latched ones.
  always_comb begin
    accept     = (state == S_IDLE) && valid;
    complete   = (state == S_ACK) && valid;
    violation  = ((state == S_WAIT) || (state == S_ACK)) && !valid;
    load_rd    = (state_n == S_ACK) && (state != S_ACK);
    rd_addr    = (state == S_IDLE) ? addr : lat_addr;
    rd_is_read = (state == S_IDLE) ? !wr_rd : !lat_wr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wr     <= 1'b0;
      lat_wdata  <= '0;
      ready      <= 1'b0;
      rdata      <= '0;
      proto_err  <= 1'b0;
      xfer_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready     <= (state_n == S_ACK);
      proto_err <= violation;
      if (accept) begin
        lat_addr  <= addr;
        lat_wr    <= wr_rd;
        lat_wdata <= wdata;
        cnt       <= 4'(WAIT_CYCLES - 1);
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      if (load_rd && rd_is_read) rdata <= mem[rd_addr];
      if (complete) begin
        xfer_count <= xfer_count + 16'd1;
        if (lat_wr) mem[lat_addr] <= lat_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: reset, table-driven transfers, random
// transfers against a transaction-level model, abort, mid-op reset, back-to-back and wrap.
module tb_mem_responder;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, wr_rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready, proto_err;
  logic [DW-1:0] rdata;
  logic [15:0]   xfer_count;

  logic          valid0, wr_rd0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ready0, proto_err0;
  logic [DW-1:0] rdata0;
  logic [15:0]   xfer_count0;

  mem_responder #(.ADDR_WIDTH(AW), .WIDTH(DW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wr_rd(wr_rd), .wdata(wdata),
    .ready(ready), .rdata(rdata), .proto_err(proto_err), .xfer_count(xfer_count)
  );

  mem_responder #(.ADDR_WIDTH(AW), .WIDTH(DW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .valid(valid0), .addr(addr0), .wr_rd(wr_rd0), .wdata(wdata0),
    .ready(ready0), .rdata(rdata0), .proto_err(proto_err0), .xfer_count(xfer_count0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [32];
  logic [15:0]   cnt_m;

  typedef struct {
    bit          wr;
    logic [4:0]  a;
    logic [7:0]  d;
    int          abort_at;
    logic [7:0]  exp_rd;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    cnt_m = '0;
  endtask

  // One transfer on the WAIT_CYCLES=2 instance; abort_at=j drops valid before edge T0+j.
  task automatic xact(input bit wr, input logic [4:0] a, input logic [7:0] d,
                      input int abort_at, input logic [7:0] exp_rd, input logic [15:0] exp_cnt);
    valid = 1'b1; wr_rd = wr; addr = a; wdata = d;
    tick();
    check("accept_ready_low", ready, 0);
    addr = ~a; wdata = ~d; wr_rd = ~wr;
    for (int j = 1; j <= W + 1; j++) begin
      if (j == abort_at) begin
        valid = 1'b0;
        tick();
        check("abort_pulse", proto_err, 1);
        check("abort_ready", ready, 0);
        tick();
        check("abort_pulse_end", proto_err, 0);
        check("abort_count", xfer_count, exp_cnt);
        return;
      end
      tick();
      if (j <= W) begin
        check("ready_timing", ready, (j == W) ? 1 : 0);
        if (j == W && !wr) check("rdata", rdata, exp_rd);
      end else begin
        check("ready_fall", ready, 0);
        check("xfer_count", xfer_count, exp_cnt);
        check("no_err", proto_err, 0);
        valid = 1'b0;
      end
    end
  endtask

  task automatic model_apply(input bit wr, input logic [4:0] a, input logic [7:0] d, input int abort_at);
    if (abort_at == 0) begin
      if (wr) mem_m[a] = d;
      cnt_m = cnt_m + 16'd1;
    end
  endtask

  initial begin
    bit          r_wr;
    logic [4:0]  r_a;
    logic [7:0]  r_d;
    int          r_ab;

    tbl[0]  = '{0, 5'd7,  8'h00, 0, 8'h00, 16'd1};
    tbl[1]  = '{1, 5'd3,  8'hA5, 0, 8'h00, 16'd2};
    tbl[2]  = '{0, 5'd3,  8'h00, 0, 8'hA5, 16'd3};
    tbl[3]  = '{1, 5'd4,  8'h5A, 1, 8'h00, 16'd3};
    tbl[4]  = '{0, 5'd4,  8'h00, 0, 8'h00, 16'd4};
    tbl[5]  = '{1, 5'd31, 8'hC3, 3, 8'h00, 16'd4};
    tbl[6]  = '{0, 5'd31, 8'h00, 0, 8'h00, 16'd5};
    tbl[7]  = '{1, 5'd31, 8'h3C, 0, 8'h00, 16'd6};
    tbl[8]  = '{0, 5'd31, 8'h00, 0, 8'h3C, 16'd7};
    tbl[9]  = '{1, 5'd0,  8'hFF, 0, 8'h00, 16'd8};
    tbl[10] = '{0, 5'd0,  8'h00, 0, 8'hFF, 16'd9};

    rst = 1'b0;
    valid = 1'b1; addr = 5'd7; wr_rd = 1'b1; wdata = 8'h55;
    valid0 = 1'b0; addr0 = '0; wr_rd0 = 1'b0; wdata0 = '0;
    model_reset();
    repeat (3) begin
      tick();
      check("rst_ready", ready, 0);
      check("rst_rdata", rdata, 0);
      check("rst_count", xfer_count, 0);
      check("rst_err", proto_err, 0);
    end
    valid = 1'b0;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      xact(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].abort_at, tbl[i].exp_rd, tbl[i].exp_cnt);
      model_apply(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].abort_at);
    end

    repeat (40) begin
      r_wr = 1'($urandom_range(0, 1));
      r_a  = 5'($urandom_range(0, 31));
      r_d  = 8'($urandom);
      r_ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      xact(r_wr, r_a, r_d, r_ab, mem_m[r_a], (r_ab == 0) ? cnt_m + 16'd1 : cnt_m);
      model_apply(r_wr, r_a, r_d, r_ab);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Mid-operation reset while the write to addr 9 sits in ACK.
    valid = 1'b1; wr_rd = 1'b1; addr = 5'd9; wdata = 8'hFF;
    tick();
    tick();
    tick();
    check("midrst_in_ack", ready, 1);
    rst = 1'b0;
    #1;
    check("midrst_ready_async", ready, 0);
    check("midrst_count_async", xfer_count, 0);
    tick();
    tick();
    valid = 1'b0;
    rst = 1'b1;
    model_reset();
    tick();
    xact(1'b0, 5'd9, 8'h00, 0, 8'h00, 16'd1);
    model_apply(1'b0, 5'd9, 8'h00, 0);

    // Back-to-back on the zero-wait instance with valid held high.
    valid0 = 1'b1; wr_rd0 = 1'b1; addr0 = 5'd0; wdata0 = 8'h11;
    tick();
    check("b2b_ack1", ready0, 1);
    addr0 = 5'd31; wdata0 = 8'h22;
    tick();
    check("b2b_fall1", ready0, 0);
    check("b2b_count1", xfer_count0, 1);
    tick();
    check("b2b_ack2", ready0, 1);
    wr_rd0 = 1'b0; addr0 = 5'd31;
    tick();
    check("b2b_fall2", ready0, 0);
    check("b2b_count2", xfer_count0, 2);
    tick();
    check("b2b_ack3", ready0, 1);
    check("b2b_rdata31", rdata0, 8'h22);
    addr0 = 5'd0;
    tick();
    check("b2b_fall3", ready0, 0);
    check("b2b_count3", xfer_count0, 3);
    tick();
    check("b2b_ack4", ready0, 1);
    check("b2b_rdata0", rdata0, 8'h11);
    tick();
    check("b2b_count4", xfer_count0, 4);
    check("b2b_no_err", proto_err0, 0);
    valid0 = 1'b0;
    tick();

    // Counter wrap: preload the count, then complete one transfer.
    force u_dut0.xfer_count = 16'hFFFF;
    #1;
    release u_dut0.xfer_count;
    valid0 = 1'b1; wr_rd0 = 1'b1; addr0 = 5'd5; wdata0 = 8'h77;
    tick();
    check("wrap_ack", ready0, 1);
    tick();
    valid0 = 1'b0;
    check("wrap_count", xfer_count0, 16'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the team's valid/ready memory interface: the slave end that the interface BFM drives. It accepts single read or write requests (addr, wr_rd, wdata) under a valid/ready handshake, inserts a configurable number of wait states, and returns read data alongside ready. It is the DUT-side memory model in the memory-interface environment, and it also serves as a reusable on-chip scratch RAM.

## Interface

Parameters:

- ADDR_WIDTH, 5, address width; memory depth is 2**ADDR_WIDTH words.
- WIDTH, 8, data word width.
- WAIT_CYCLES, 2, wait states inserted before ready; legal range 0..15.

Ports:

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- valid  input  1  request valid, driven by the initiator.
- addr  input  ADDR_WIDTH  request address.
- wr_rd  input  1  1 = write, 0 = read.
- wdata  input  WIDTH  write data.
- ready  output  1  transfer acknowledge, registered.
- rdata  output  WIDTH  read data, registered.
- proto_err  output  1  one-cycle pulse on a protocol violation.
- xfer_count  output  16  number of completed transfers; wraps at 0xFFFF to 0.

## Operation

- Reset (rst low) is asynchronous and immediate:
  - ready=0, rdata=0, proto_err=0, xfer_count=0, FSM to IDLE.
  - All memory words cleared to 0.
  - An in-flight request is discarded and no write occurs.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with valid=1, latch addr, wr_rd and wdata.
  - If WAIT_CYCLES=0, go to ACK; otherwise go to WAIT with the wait counter loaded to WAIT_CYCLES-1.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter is 0, go to ACK.
- ACK:
  - ready=1.
  - For a read, rdata = mem[latched addr]; it is loaded on the edge entering ACK.
  - The handshake completes on the edge where valid=1 and ready=1.
  - On completion, a write stores the latched wdata to mem[latched addr], xfer_count increments, and the FSM returns to IDLE with ready=0.
- Latched values only:
  - addr, wr_rd and wdata changes after the accept edge are ignored.
  - The initiator must hold them stable, but the block does not check this.
- Protocol violation: valid sampled 0 while in WAIT or ACK means the request is abandoned.
  - proto_err pulses for one cycle and the FSM goes to IDLE.
  - ready=0, no write, xfer_count unchanged.
- rdata holds its last read value through writes and idle cycles.
- A write followed by a read of the same address returns the new data, because the write commits at completion, before the read is accepted.
- xfer_count counts reads and writes alike.

## Timing

- Let T0 be the accept edge (IDLE, valid=1).
- ready is high between edges T0+WAIT_CYCLES and T0+WAIT_CYCLES+1.
- The handshake completes at edge T0+WAIT_CYCLES+1.
- Completion edge:
  - The write is committed and xfer_count updated at this edge.
  - ready falls after this edge.
- No request is accepted on the completion edge itself. The earliest next accept edge is completion+1, so back-to-back transfers take at least WAIT_CYCLES+2 cycles each.
- If valid stays high through completion, the following edge accepts it as a new request.
- proto_err is high for exactly the cycle after the edge that detects the violation.
- The BFM samples ready/rdata at #0 after the edge and drives outputs at #1, so all responder outputs are flop outputs with no combinational path from the inputs.

## Test plan

- Reset: hold rst=0 for 3 cycles with valid=1.
  - Required: ready=0, rdata=0, xfer_count=0, no proto_err.
  - Release rst, then read addr 7. Required: rdata=0x00.
- Write/read, WAIT_CYCLES=2: write addr 3, wdata 0xA5, valid rising before T0.
  - Required: ready high only in cycle T0+2..T0+3, xfer_count=1.
  - Then read addr 3. Required: rdata=0xA5 with ready, xfer_count=2.
- Back-to-back, WAIT_CYCLES=0: valid held high for writes 0x11 to addr 0 and 0x22 to addr 31, then a read of addr 31.
  - Required: ready pulses every 2 cycles and read rdata=0x22.
  - Also required: addr 31 wraps nothing, and xfer_count=3.
- Protocol abort: start a write of 0x5A to addr 4, then drop valid in WAIT.
  - Required: proto_err one-cycle pulse, ready stays 0, and a later read of addr 4 returns 0x00.
  - Also required: xfer_count unchanged.
- Mid-operation reset: assert rst=0 while in ACK of a write of 0xFF to addr 9.
  - Required: ready drops immediately and a later read of addr 9 returns 0x00.
- Counter wrap: preload via 65535 transfers (or force), then complete one more.
  - Required: xfer_count=0x0000.
